mult_share_sched: RTL and testbench

Round-robin scheduler that shares one combinational 8x8 approximate multiplier (the CSA/Dadda-class unsigned multiplier) between NREQ requesters. It launches one operand pair at a time and holds the operands stable for a programmable settle window, so the multiplier's long combinational path never has to close in one cycle. It then returns the 16-bit product to the granted requester with a valid/ready response. It sits between the accelerator's operand sources and the single shared multiplier instance.

---
 rtl/mult_share_sched.sv | 177 +++++++++++++++++
 tb/tb_mult_share_sched.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_sched.sv
// mult_share_sched
//
// Round-robin scheduler that time-shares one combinational 8x8 multiplier
// between NREQ requesters. One operand pair is launched at a time. The
// operands are held in registers for SETTLE_CYC clock periods before the
// product is sampled, so the multiplier path gets several cycles to settle.
// The sampled product is then returned through a valid/ready response.
//
// Ports:
//   clk        - clock, rising edge
//   rst_n      - asynchronous active-low reset
//   req_valid  - per-requester operand valid
//   req_a      - operand A, requester i on bits [8i+7:8i]
//   req_b      - operand B, same packing as req_a
//   req_ready  - one-hot accept, only while idle
//   mul_a      - registered operand A driven to the shared multiplier
//   mul_b      - registered operand B driven to the shared multiplier
//   mul_p      - product returned combinationally by the multiplier
//   rsp_valid  - response valid
//   rsp_ready  - response consumer ready
//   rsp_id     - requester that owns rsp_p
//   rsp_p      - registered product
//   busy       - high whenever an operation is in flight or awaiting hand-off
//   op_cnt     - completed response count, wraps at 16 bits

module mult_share_sched #(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int SETTLE_CYC = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_a,
  input  logic [8*NREQ-1:0]    req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_p,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [15:0]          rsp_p,
  output logic                 busy,
  output logic [15:0]          op_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0]     CNT_LOAD = 4'(SETTLE_CYC - 1);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] scan_idx;
  logic           gnt_found;
  logic [3:0]     cnt;
  logic           grant_en;
  logic           sample_en;
  logic           hs_en;
  logic           cnt_dec;

  // Round-robin search: walk the requesters starting at ptr, wrapping at
  // NREQ, and keep the first one that is asserting valid. The wrap is done
  // by subtraction so NREQ need not be a power of two.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (int'(ptr) + k >= NREQ) begin
        scan_idx = IDW'(int'(ptr) + k - NREQ);
      end else begin
        scan_idx = IDW'(int'(ptr) + k);
      end
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  // Accept is combinational so the requester sees it in the grant cycle.
  // It is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    req_ready = '0;
    if (rst_n && (state == IDLE) && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The strobes below are mutually exclusive. The datapath registers act on
  // exactly one of them per edge.
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    sample_en = 1'b0;
    hs_en     = 1'b0;
    cnt_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_found) begin
          grant_en  = 1'b1;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          sample_en = 1'b1;
          state_nxt = RESP;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          hs_en     = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // mul_a/mul_b are loaded only on a grant. They keep the last operands
  // afterwards, so the shared multiplier does not toggle while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_id    <= '0;
      rsp_p     <= '0;
      rsp_valid <= 1'b0;
      op_cnt    <= '0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      if (grant_en) begin
        mul_a  <= req_a[8*int'(gnt_idx) +: 8];
        mul_b  <= req_b[8*int'(gnt_idx) +: 8];
        rsp_id <= gnt_idx;
        ptr    <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        cnt    <= CNT_LOAD;
      end
      if (cnt_dec) begin
        cnt <= cnt - 4'd1;
      end
      if (sample_en) begin
        rsp_p     <= mul_p;
        rsp_valid <= 1'b1;
      end
      if (hs_en) begin
        rsp_valid <= 1'b0;
        op_cnt    <= op_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// tb_mult_share_sched
//
// Self-checking bench for mult_share_sched with NREQ=4 and SETTLE_CYC=3.
// An exact multiplier stub is connected to mul_a/mul_b/mul_p. A
// transaction-level reference model tracks grants, settle age, the
// outstanding response and the completion count. A compare process checks
// every DUT output against that model on each falling edge. Directed
// sequences add hand-computed literal expectations.

module tb_mult_share_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int S    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_p;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_p;
  logic              busy;
  logic [15:0]       op_cnt;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  assign mul_p = {8'd0, mul_a} * {8'd0, mul_b};

  mult_share_sched #(
    .NREQ       (NREQ),
    .IDW        (IDW),
    .SETTLE_CYC (S)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  // Reference model. It keeps the operation in flight, its age since the
  // grant, the pending response, and a plain completion count. The model
  // is bypassed for op_cnt only by op_bias, which accounts for the
  // preloaded counter in the wrap sequence.
  int          m_ptr;
  bit          m_active;
  bit          m_resp;
  int          m_age;
  int          m_id;
  logic [7:0]  m_a;
  logic [7:0]  m_b;
  logic [15:0] m_p;
  logic [15:0] m_opcnt;
  logic [15:0] op_bias;
  int          m_grants = 0;
  int          cyc = 0;
  int          g_id[$];
  int          g_cyc[$];
  int          pick;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] pack(input logic [7:0] x0, input logic [7:0] x1,
                                       input logic [7:0] x2, input logic [7:0] x3);
    return {x3, x2, x1, x0};
  endfunction

  always_comb pick = rr_pick(req_valid, m_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr    <= 0;
      m_active <= 1'b0;
      m_resp   <= 1'b0;
      m_age    <= 0;
      m_id     <= 0;
      m_a      <= 8'd0;
      m_b      <= 8'd0;
      m_p      <= 16'd0;
      m_opcnt  <= 16'd0;
    end else begin
      cyc <= cyc + 1;
      if (m_resp) begin
        if (rsp_ready) begin
          m_resp  <= 1'b0;
          m_opcnt <= m_opcnt + 16'd1;
        end
      end else if (m_active) begin
        m_age <= m_age + 1;
        if (m_age + 1 == S) begin
          m_active <= 1'b0;
          m_resp   <= 1'b1;
          m_p      <= {8'd0, m_a} * {8'd0, m_b};
        end
      end else if (pick >= 0) begin
        m_active <= 1'b1;
        m_age    <= 0;
        m_id     <= pick;
        m_a      <= req_a[8*pick +: 8];
        m_b      <= req_b[8*pick +: 8];
        m_ptr    <= (pick + 1) % NREQ;
        m_grants <= m_grants + 1;
        g_id.push_back(pick);
        g_cyc.push_back(cyc);
      end
    end
  end

  function automatic logic [NREQ-1:0] exp_ready();
    if (m_active || m_resp || pick < 0) return '0;
    return NREQ'(1) << pick;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the reference model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      checkOutput("cyc_req_ready", 32'(req_ready), 32'(exp_ready()));
      checkOutput("cyc_mul_a",     32'(mul_a),     32'(m_a));
      checkOutput("cyc_mul_b",     32'(mul_b),     32'(m_b));
      checkOutput("cyc_rsp_valid", 32'(rsp_valid), 32'(m_resp));
      checkOutput("cyc_rsp_id",    32'(rsp_id),    32'(m_id));
      checkOutput("cyc_rsp_p",     32'(rsp_p),     32'(m_p));
      checkOutput("cyc_busy",      32'(busy),      32'(m_active || m_resp));
      checkOutput("cyc_op_cnt",    32'(op_cnt),    32'(16'(m_opcnt + op_bias)));
    end
  end

  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [31:0] a,
                               input logic [31:0] b, input logic rr);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    rsp_ready = rr;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    checkOutput({tag, "_mul_a"},     32'(mul_a),     32'd0);
    checkOutput({tag, "_mul_b"},     32'(mul_b),     32'd0);
    checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    checkOutput({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    checkOutput({tag, "_rsp_p"},     32'(rsp_p),     32'd0);
    checkOutput({tag, "_busy"},      32'(busy),      32'd0);
    checkOutput({tag, "_op_cnt"},    32'(op_cnt),    32'd0);
  endtask

  task automatic waitGrants(input int target, input int budget);
    int b = 0;
    while (m_grants < target && b < budget) begin
      @(negedge clk);
      b++;
    end
    checkOutput("grant_wait", 32'(m_grants >= target), 32'd1);
  endtask

  task automatic waitResp(input int budget);
    int b = 0;
    while (!m_resp && b < budget) begin
      @(negedge clk);
      b++;
    end
    checkOutput("resp_wait", 32'(m_resp), 32'd1);
  endtask

  task automatic waitIdle(input int budget);
    int b = 0;
    while ((m_active || m_resp) && b < budget) begin
      @(negedge clk);
      b++;
    end
    checkOutput("idle_wait", 32'(!m_active && !m_resp), 32'd1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    int tgt;
    op_bias = 16'd0;
    rst_n   = 1'b1;
    applyStimulus('0, '0, '0, 1'b0);

    // Reset: held for three cycles, then idle with no requests.
    #1 rst_n = 1'b0;
    #1 checkAllZero("rst_assert");
    repeat (3) @(negedge clk);
    checkAllZero("rst_hold");
    #1 rst_n = 1'b0;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    checkAllZero("rst_idle");

    // Single operation from requester 2: 13 * 11 = 143.
    #1 applyStimulus(4'b0100, pack(0, 0, 13, 0), pack(0, 0, 11, 0), 1'b1);
    #1 checkOutput("single_grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    checkOutput("single_mul_a", 32'(mul_a), 32'd13);
    checkOutput("single_mul_b", 32'(mul_b), 32'd11);
    checkOutput("single_busy", 32'(busy), 32'd1);
    #1 req_valid = '0;
    @(negedge clk);
    checkOutput("single_vld_t1", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("single_vld_t2", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    checkOutput("single_vld_t3", 32'(rsp_valid), 32'd1);
    checkOutput("single_rsp_id", 32'(rsp_id), 32'd2);
    checkOutput("single_rsp_p", 32'(rsp_p), 32'd143);
    @(negedge clk);
    checkOutput("single_done_vld", 32'(rsp_valid), 32'd0);
    checkOutput("single_op_cnt", 32'(op_cnt), 32'd1);

    // Round robin with all four requesters valid; reset first so the
    // pointer starts at requester 0.
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    #1 applyStimulus(4'b1111, pack(3, 50, 100, 255), pack(7, 5, 2, 255), 1'b1);
    base = g_id.size();
    waitGrants(m_grants + 6, 60);
    #1 req_valid = '0;
    if (g_id.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        checkOutput("rr_order", 32'(g_id[base + i]), 32'(i % NREQ));
      end
      for (int i = 1; i < 6; i++) begin
        checkOutput("rr_spacing", 32'(g_cyc[base + i] - g_cyc[base + i - 1]), 32'(S + 2));
      end
    end
    waitIdle(20);
    checkOutput("rr_op_cnt", 32'(op_cnt), 32'd6);
    checkOutput("rr_last_p", 32'(rsp_p), 32'd250);

    // Back-pressure: requester 1 computes 200 * 3 = 600 while requester 3
    // waits behind the held response.
    #1 applyStimulus(4'b0010, pack(0, 200, 0, 0), pack(0, 3, 0, 0), 1'b0);
    tgt = m_grants + 1;
    waitGrants(tgt, 20);
    #1 applyStimulus(4'b1000, pack(0, 200, 0, 9), pack(0, 3, 0, 9), 1'b0);
    waitResp(20);
    for (int i = 0; i < 6; i++) begin
      checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rsp_p", 32'(rsp_p), 32'd600);
      checkOutput("bp_rsp_id", 32'(rsp_id), 32'd1);
      checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
      checkOutput("bp_mul_a", 32'(mul_a), 32'd200);
      checkOutput("bp_mul_b", 32'(mul_b), 32'd3);
      @(negedge clk);
    end
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_op_cnt", 32'(op_cnt), 32'd7);
    checkOutput("bp_done_vld", 32'(rsp_valid), 32'd0);
    tgt = m_grants + 1;
    waitGrants(tgt, 20);
    #1 req_valid = '0;
    waitIdle(20);
    checkOutput("bp_r3_p", 32'(rsp_p), 32'd81);
    checkOutput("bp_op_cnt2", 32'(op_cnt), 32'd8);

    // Reset in the middle of SETTLE with one settle cycle remaining.
    // Requester 1 is granted first so that the pointer sits at 2.
    #1 applyStimulus(4'b0010, pack(0, 77, 0, 0), pack(0, 2, 0, 0), 1'b1);
    tgt = m_grants + 1;
    waitGrants(tgt, 20);
    #1 req_valid = '0;
    @(negedge clk);
    checkOutput("mid_busy", 32'(busy), 32'd1);
    checkOutput("mid_vld", 32'(rsp_valid), 32'd0);
    #1 applyStimulus(4'b0101, pack(40, 0, 60, 0), pack(2, 0, 3, 0), 1'b1);
    #1 rst_n = 1'b0;
    #1 checkAllZero("mid_rst");
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_regrant_a", 32'(mul_a), 32'd40);
    checkOutput("mid_regrant_b", 32'(mul_b), 32'd2);
    checkOutput("mid_regrant_id", 32'(rsp_id), 32'd0);
    tgt = m_grants + 1;
    waitGrants(tgt, 20);
    #1 req_valid = '0;
    waitIdle(20);
    checkOutput("mid_op_cnt", 32'(op_cnt), 32'd2);
    checkOutput("mid_last_p", 32'(rsp_p), 32'd180);

    // Counter wrap with the largest operands: 255 * 255 = 65025.
    #1 force dut.op_cnt = 16'hFFFF;
    op_bias = 16'hFFFF - m_opcnt;
    #1 release dut.op_cnt;
    #1 checkOutput("wrap_preload", 32'(op_cnt), 32'hFFFF);
    applyStimulus(4'b0001, pack(255, 0, 0, 0), pack(255, 0, 0, 0), 1'b1);
    tgt = m_grants + 1;
    waitGrants(tgt, 20);
    #1 req_valid = '0;
    waitResp(20);
    checkOutput("wrap_rsp_p", 32'(rsp_p), 32'd65025);
    @(negedge clk);
    checkOutput("wrap_op_cnt", 32'(op_cnt), 32'd0);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
